// File: rtl/mac3_window.sv
// Sliding three-sample multiply-accumulate (a*b+c) over a valid-qualified stream.
// Build option: define MAC3_SAT_EN to saturate data_out on overflow instead of wrapping.
module mac3_window #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             validi,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clr,
    output logic             valido,
    output logic [OUT_W-1:0] data_out,
    output logic             ovf,
    output logic [CNT_W-1:0] result_cnt,
    output logic [1:0]       dbg_state,
    output logic [WIDTH-1:0] dbg_window_oldest
);
    // Handshake: validi qualifies data_in for one cycle; valido is a one-cycle
    // pulse per result with no ready, so the consumer must take every pulse.

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2, FULL = 2'd3} fill_t;

    localparam int FW = 2 * WIDTH + 1;

    fill_t            state;
    logic [WIDTH-1:0] s0, s1, s2;
    logic [FW-1:0]    full;
    logic [OUT_W-1:0] res_d;
    logic             wide;
    logic             issue;

    // s1 is the sample two valid cycles back, s0 the previous one.
    assign full  = FW'(s1) * FW'(s0) + FW'(data_in);
    assign issue = validi && !clr && (state == TWO || state == FULL);

    generate
        if (OUT_W < FW) begin : g_ovf
            assign wide = |full[FW-1:OUT_W];
        end else begin : g_no_ovf
            assign wide = 1'b0;
        end
    endgenerate

`ifdef MAC3_SAT_EN
    assign res_d = wide ? '1 : full[OUT_W-1:0];
`else
    assign res_d = full[OUT_W-1:0];
`endif

    assign dbg_state         = state;
    assign dbg_window_oldest = s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            s0         <= '0;
            s1         <= '0;
            s2         <= '0;
            valido     <= 1'b0;
            data_out   <= '0;
            ovf        <= 1'b0;
            result_cnt <= '0;
        end else begin
            valido <= issue;
            ovf    <= issue && wide;
            if (issue) begin
                data_out   <= res_d;
                result_cnt <= result_cnt + CNT_W'(1);
            end

            // clr wins over validi: the sample is dropped and the window emptied.
            if (clr) begin
                state <= EMPTY;
                s0    <= '0;
                s1    <= '0;
                s2    <= '0;
            end else if (validi) begin
                s2 <= s1;
                s1 <= s0;
                s0 <= data_in;
                case (state)
                    EMPTY:   state <= ONE;
                    ONE:     state <= TWO;
                    default: state <= FULL;
                endcase
            end else begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: doc/mac3_window.md
# mac3_window

Parametrised successor to the three-sample multiply-accumulate datapath. The block watches a valid-qualified input stream and, after every run of three or more consecutive valid samples, produces `a*b+c` over a sliding window of the last three samples. It adds configurable widths, a synchronous window clear, a result counter and overflow reporting. It sits between the sample source and the result consumer, and is checked by the team's property module for this datapath.

## Interface
- `WIDTH`, 32: input sample width (unsigned); legal range 2..32.
- `OUT_W`, 32: result width; legal range 1..2*WIDTH+1.
- `CNT_W`, 16: width of the result counter.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `validi`  in  1  `data_in` carries a sample this cycle.
- `data_in`  in  WIDTH  sample.
- `clr`  in  1  synchronous window clear; discards window contents.
- `valido`  out  1  `data_out` holds a new result this cycle (one-cycle pulse per result).
- `data_out`  out  OUT_W  result.
- `ovf`  out  1  the current result exceeded OUT_W bits; valid only when `valido`=1, otherwise 0.
- `result_cnt`  out  CNT_W  number of results produced since reset; wraps modulo 2^CNT_W.

## Operation
- Window registers: `s2` holds the oldest sample, `s1` the middle sample, `s0` the newest. On a valid sample: `s2`<=`s1`, `s1`<=`s0`, `s0`<=`data_in`.
- Fill FSM states:
  - EMPTY --validi--> ONE --validi--> TWO --validi--> FULL.
  - FULL --validi--> FULL.
  - From any state, `validi`=0 -> EMPTY.
  - From any state, `clr`=1 -> EMPTY.
- A result is issued when `validi`=1 arrives while the FSM is in TWO or FULL.
  - Operands: a = sample from two valid cycles back, b = sample from one valid cycle back, c = current `data_in`.
  - Full result is 2*WIDTH+1 bits: a*b+c, unsigned.
- Consecutive valid samples produce overlapping windows, i.e. one result per valid sample once the window is full.
- `clr` overrides `validi` in the same cycle: the sample is dropped, no result is issued, and the FSM goes to EMPTY.
- `data_out` holds the last result while `valido`=0.
- `result_cnt` increments once per `valido` pulse.
- Any result wider than OUT_W sets `ovf`=1 in the same cycle as `valido`.

## Timing
- Latency: `valido` and `data_out` are registered. They are valid in the cycle after the edge that samples the third consecutive `validi`. This satisfies `validi ##1 validi ##1 validi |=> valido`.
- Runs of zero, one or two consecutive `validi` never produce `valido`.
- Throughput: one result per clock in steady state.
- Reset (`rst_n`=0) is asynchronous and immediate:
  - `valido`=0, `data_out`=0, `ovf`=0, `result_cnt`=0.
  - FSM goes to EMPTY and the window registers are cleared.
  - All outputs hold these values for as long as `rst_n`=0.
- Reset mid-run discards partial windows. After release, three fresh consecutive valid samples are required before the next result.
- `result_cnt` wraps from 2^CNT_W-1 to 0 with no flag.
- No backpressure: the consumer must accept every `valido` pulse.

## Configuration
- `MAC3_SAT_EN` defined: a result wider than OUT_W saturates `data_out` to 2^OUT_W-1 (all ones), with `ovf`=1.
- `MAC3_SAT_EN` undefined: `data_out` is the full result truncated to its low OUT_W bits (modulo wrap), with `ovf`=1.
- `ovf` behaviour is identical in both builds.

## Test plan
All cases use WIDTH=32, OUT_W=32.
- Basic window: reset, then validi=1 with `data_in` 3,4,5 on three consecutive cycles -> one cycle later `valido`=1, `data_out`=17, `ovf`=0, `result_cnt`=1.
- Sliding: continue the run with 6 then 7 -> `data_out`=26, then 37, on consecutive cycles; `result_cnt`=3.
- Broken run: `data_in` 1,2, then one idle cycle (`validi`=0), then 3,4 -> `valido` stays 0 throughout. `clr` asserted on the third sample of a 9,9,9 run -> no `valido`.
- Overflow: `data_in` 0x10000, 0x10000, 0x1 -> `ovf`=1. With `MAC3_SAT_EN` undefined, `data_out`=0x1; with it defined, `data_out`=0xFFFFFFFF.
- Reset mid-operation: after two valid samples, pulse `rst_n` low between clock edges -> outputs go to 0 immediately. After release, samples 2,3,4 -> `data_out`=10 one cycle after the third sample, `result_cnt`=1.
- Counter wrap: with CNT_W=2, produce 5 results -> `result_cnt` sequence 1,2,3,0,1.
